// File: rtl/divclk_pkg.sv
// Shared types and defaults for the divided-clock receive path.
// Optional period checking is enabled by defining DIVCLK_PERIOD_CHECK_EN.
package divclk_pkg;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_LOST    = 2'd2
  } divclk_state_e;

  localparam int unsigned DefSyncStages = 2;
  localparam int unsigned DefCntW       = 16;
  localparam int unsigned DefTimeout    = 1000;
  localparam int unsigned DefLockCount  = 4;
  localparam int unsigned DefTol        = 1;

  // Saturation value of a default-width period/idle counter.
  localparam logic [DefCntW-1:0] DefCntMax = {DefCntW{1'b1}};

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer plus history flop with registered rise/fall ticks.
// The *_pre_o outputs are the unregistered edge flags, one cycle ahead of the ticks.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic async_i,
  output logic rise_pre_o,
  output logic fall_pre_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_lvl;

  // Shift the async input through the synchronizer and detect edges vs. history.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], async_i};
    sync_lvl = sync_q[SYNC_STAGES-1];
    hist_d   = sync_lvl;
    rise_d   = sync_lvl & ~hist_q;
    fall_d   = ~sync_lvl & hist_q;
  end

  // Synchronizer, history and tick registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_pre_o = rise_d;
  assign fall_pre_o = fall_d;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;

endmodule

// File: rtl/divclk_tick_rx.sv
// Divided-clock receiver: edge ticks, loss detection and (optionally) period lock.
// Define DIVCLK_PERIOD_CHECK_EN to build the period measurement and lock logic.
module divclk_tick_rx
  import divclk_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned TIMEOUT     = DefTimeout,
  parameter int unsigned LOCK_COUNT  = DefLockCount,
  parameter int unsigned TOL         = DefTol
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             divided_clk,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             clk_lost
);

  if (SYNC_STAGES < 2 || LOCK_COUNT == 0 || TOL >= TIMEOUT) begin : g_bad_cfg
    $error("divclk_tick_rx: invalid parameter set");
  end

  localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

  logic          rise_pre, fall_pre, any_pre, timeout;
  logic [CNT_W-1:0] idle_q, idle_d, idle_inc;
  divclk_state_e state_q, state_d;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_in    (clk_in),
    .rst       (rst),
    .async_i   (divided_clk),
    .rise_pre_o(rise_pre),
    .fall_pre_o(fall_pre),
    .rise_o    (rise_tick),
    .fall_o    (fall_tick)
  );

  // Idle counter reads 0 in a tick cycle; any edge beats a coincident timeout.
  always_comb begin
    any_pre  = rise_pre | fall_pre;
    idle_inc = (idle_q == TimeoutVal) ? idle_q : idle_q + CNT_W'(1);
    idle_d   = any_pre ? '0 : idle_inc;
    timeout  = ~any_pre & (idle_inc == TimeoutVal);
  end

`ifdef DIVCLK_PERIOD_CHECK_EN
  localparam int unsigned      MatchW   = $clog2(LOCK_COUNT + 1);
  localparam logic [MatchW-1:0] LockVal = MatchW'(LOCK_COUNT);
  localparam logic [CNT_W-1:0]  TolVal  = CNT_W'(TOL);

  logic [CNT_W-1:0]  per_cnt_q, per_cnt_d, meas, diff;
  logic [CNT_W-1:0]  prev_q, prev_d, period_q, period_d;
  logic [MatchW-1:0] match_q, match_d, match_inc;
  logic              armed_q, armed_d, have_prev_q, have_prev_d, pv_q, pv_d, in_tol;

  // Period measurement, tolerance match and ACQUIRE/LOCKED/LOST sequencing.
  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    have_prev_d = have_prev_q;
    prev_d      = prev_q;
    match_d     = match_q;
    period_d    = period_q;
    pv_d        = 1'b0;
    // meas is the rise-to-rise distance that this rise closes.
    meas        = (per_cnt_q == CntMax) ? per_cnt_q : per_cnt_q + CNT_W'(1);
    per_cnt_d   = rise_pre ? '0 : meas;
    diff        = (meas >= prev_q) ? meas - prev_q : prev_q - meas;
    in_tol      = have_prev_q & (meas != CntMax) & (prev_q != CntMax) & (diff <= TolVal);
    match_inc   = match_q + MatchW'(1);
    if (timeout) begin
      state_d     = ST_LOST;
      armed_d     = 1'b0;
      have_prev_d = 1'b0;
      match_d     = '0;
    end else if (rise_pre) begin
      if (state_q == ST_LOST || !armed_q) begin
        // First rise only starts the period counter.
        state_d     = ST_ACQUIRE;
        armed_d     = 1'b1;
        have_prev_d = 1'b0;
        match_d     = '0;
      end else begin
        pv_d        = 1'b1;
        period_d    = meas;
        prev_d      = meas;
        have_prev_d = 1'b1;
        if (!in_tol) begin
          state_d = ST_ACQUIRE;
          match_d = '0;
        end else if (state_q == ST_ACQUIRE) begin
          match_d = match_inc;
          if (match_inc == LockVal) state_d = ST_LOCKED;
        end
      end
    end
  end

  // Period-check state.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      per_cnt_q   <= '0;
      prev_q      <= '0;
      period_q    <= '0;
      match_q     <= '0;
      armed_q     <= 1'b0;
      have_prev_q <= 1'b0;
      pv_q        <= 1'b0;
    end else begin
      per_cnt_q   <= per_cnt_d;
      prev_q      <= prev_d;
      period_q    <= period_d;
      match_q     <= match_d;
      armed_q     <= armed_d;
      have_prev_q <= have_prev_d;
      pv_q        <= pv_d;
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;
  assign locked       = (state_q == ST_LOCKED);
`else
  // Reduced FSM: only loss detection and recovery on the next rise.
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = ST_LOST;
    end else if (rise_pre) begin
      state_d = ST_ACQUIRE;
    end
  end

  assign period       = '0;
  assign period_valid = 1'b0;
  assign locked       = 1'b0;
`endif

  // FSM and idle counter registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACQUIRE;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
    end
  end

  assign clk_lost = (state_q == ST_LOST);

endmodule
